// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the frame-buffer port arbiter.
// Optional feature macro: FB_ARB_CLEAR_EN (post-reset zero-fill of the frame buffer).
package fb_arb_pkg;

    localparam int DEF_ADDR_WIDTH  = 19;
    localparam int DEF_DATA_WIDTH  = 3;
    localparam int DEF_H_PIXELS    = 640;
    localparam int DEF_V_PIXELS    = 480;
    localparam int DEF_FIFO_DEPTH  = 8;
    localparam int DEF_RAM_LATENCY = 2;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } fb_state_e;

    // Number of pixels in one frame.
    function automatic int fb_pixels(input int h, input int v);
        return h * v;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous pixel write FIFO. A push while full is ignored, even if a pop
// happens in the same cycle. Flush empties the FIFO; a push in the flush cycle
// is kept as the sole entry.
module fb_wr_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && (flush || !full);
    assign rd_en = pop && !empty && !flush;
    assign dout  = mem[rptr];

    // Storage array; a push during flush lands in slot 0.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[flush ? '0 : wptr] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= wr_en ? PTR_W'(1) : '0;
            count <= wr_en ? CNT_W'(1) : '0;
        end else begin
            if (wr_en) wptr <= wptr + PTR_W'(1);
            if (rd_en) rptr <= rptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares the single-port frame-buffer RAM between the VGA read stream and the
// UART pixel write stream. Reads win every cycle; pixels wait in a small FIFO
// and drain into idle cycles at an auto-incrementing, frame-wrapping address.
// Optional feature macro: FB_ARB_CLEAR_EN adds a zero-fill pass after reset.
//
// Handshakes: there is no backpressure anywhere. wr_valid is a one-cycle
// strobe qualifying wr_data (dropped and counted when the FIFO is full);
// rd_req is a one-cycle request qualifying rd_addr, answered by a one-cycle
// rd_valid with rd_data exactly RAM_LATENCY cycles later.
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int H_PIXELS    = DEF_H_PIXELS,
    parameter int V_PIXELS    = DEF_V_PIXELS,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int RAM_LATENCY = DEF_RAM_LATENCY
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        wr_sof,
    input  logic                        rd_req,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    output logic                        rd_valid,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [ADDR_WIDTH-1:0]       ram_addr,
    output logic [DATA_WIDTH-1:0]       ram_wdata,
    output logic                        ram_we,
    input  logic [DATA_WIDTH-1:0]       ram_q,
    output logic                        frame_done,
    output logic                        overflow,
    output logic [15:0]                 drop_cnt,
    output logic                        busy,
    output fb_state_e                   state_dbg,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_dbg
);

    localparam int FB_PIXELS = fb_pixels(H_PIXELS, V_PIXELS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_PIXELS - 1);
`ifdef FB_ARB_CLEAR_EN
    localparam fb_state_e RESET_STATE = S_CLEAR;
`else
    localparam fb_state_e RESET_STATE = S_RUN;
`endif

    fb_state_e              state_q;
    fb_state_e              state_d;
    logic                   in_clear;
    logic [ADDR_WIDTH-1:0]  wr_addr_q;
    logic [ADDR_WIDTH-1:0]  last_addr_q;
    logic [DATA_WIDTH-1:0]  fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic                   drop;
    logic [RAM_LATENCY-1:0] rd_vld_sr;
    logic [RAM_LATENCY-1:0] rd_zero_sr;

`ifdef FB_ARB_CLEAR_EN
    logic [ADDR_WIDTH-1:0]  clr_cnt_q;

    // Clear counter walks the frame while in S_CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt_q <= '0;
        end else if (state_q == S_CLEAR) begin
            clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
        end
    end

    assign in_clear = (state_q == S_CLEAR);
`else
    assign in_clear = 1'b0;
`endif

    assign busy      = in_clear;
    assign state_dbg = state_q;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_wr_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (wr_sof),
        .push  (wr_valid),
        .pop   (fifo_pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .count (fifo_level_dbg),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RESET_STATE;
        else     state_q <= state_d;
    end

    // Next state: leave the clear pass after the last frame address.
    always_comb begin
        state_d = state_q;
`ifdef FB_ARB_CLEAR_EN
        if (state_q == S_CLEAR && clr_cnt_q == LAST_ADDR) state_d = S_RUN;
`else
        state_d = S_RUN;
`endif
    end

    // RAM port arbitration: clear pass, then reads, then buffered pixels.
    always_comb begin
        ram_we    = 1'b0;
        ram_wdata = '0;
        ram_addr  = last_addr_q;
        fifo_pop  = 1'b0;
        if (rst) begin
            ram_addr = '0;
`ifdef FB_ARB_CLEAR_EN
        end else if (in_clear) begin
            ram_we   = 1'b1;
            ram_addr = clr_cnt_q;
`endif
        end else if (rd_req) begin
            ram_addr = rd_addr;
        end else if (!fifo_empty && !wr_sof) begin
            fifo_pop  = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = wr_addr_q;
            ram_wdata = fifo_dout;
        end
    end

    assign frame_done = fifo_pop && (wr_addr_q == LAST_ADDR);
    assign drop       = wr_valid && !wr_sof && fifo_full;

    // Idle cycles keep presenting the previous RAM address.
    always_ff @(posedge clk) begin
        if (rst) last_addr_q <= '0;
        else     last_addr_q <= ram_addr;
    end

    // Pixel write address: restarts on start-of-frame, wraps at frame end.
    always_ff @(posedge clk) begin
        if (rst || wr_sof) begin
            wr_addr_q <= '0;
        end else if (fifo_pop) begin
            wr_addr_q <= (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_WIDTH'(1);
        end
    end

    // Read-return pipeline matching the RAM latency; clear-pass reads return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_sr  <= '0;
            rd_zero_sr <= '0;
        end else begin
            rd_vld_sr[0]  <= rd_req;
            rd_zero_sr[0] <= rd_req && in_clear;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                rd_vld_sr[i]  <= rd_vld_sr[i-1];
                rd_zero_sr[i] <= rd_zero_sr[i-1];
            end
        end
    end

    assign rd_valid = rd_vld_sr[RAM_LATENCY-1];
    assign rd_data  = (rd_valid && !rd_zero_sr[RAM_LATENCY-1]) ? ram_q : '0;

    // Drop tracking: sticky flag per frame, saturating counter per reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (wr_sof)    overflow <= 1'b0;
            else if (drop) overflow <= 1'b1;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter on a small 8x4 frame with a 2-cycle RAM model.
// Honours FB_ARB_CLEAR_EN when defined.
module tb_fb_port_arbiter;
    import fb_arb_pkg::*;

    localparam int AW  = 19;
    localparam int DW  = 3;
    localparam int HP  = 8;
    localparam int VP  = 4;
    localparam int FB  = HP * VP;
    localparam int WEW = 32 + 1 + DW + AW;
    localparam int REW = 32 + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data  = '0;
    logic          wr_sof   = 1'b0;
    logic          rd_req   = 1'b0;
    logic [AW-1:0] rd_addr  = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_q;
    logic          frame_done;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic          busy;
    fb_state_e     state_dbg;
    logic [3:0]    fifo_level_dbg;

    fb_port_arbiter #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .H_PIXELS (HP), .V_PIXELS (VP),
        .FIFO_DEPTH (8), .RAM_LATENCY (2)
    ) dut (
        .clk (clk), .rst (rst), .wr_valid (wr_valid), .wr_data (wr_data),
        .wr_sof (wr_sof), .rd_req (rd_req), .rd_addr (rd_addr),
        .rd_valid (rd_valid), .rd_data (rd_data), .ram_addr (ram_addr),
        .ram_wdata (ram_wdata), .ram_we (ram_we), .ram_q (ram_q),
        .frame_done (frame_done), .overflow (overflow), .drop_cnt (drop_cnt),
        .busy (busy), .state_dbg (state_dbg), .fifo_level_dbg (fifo_level_dbg)
    );

    // ---------------- RAM model: address reg + output reg ----------------
    logic [DW-1:0] mem [FB];
    logic [AW-1:0] ram_addr_r;
    logic [DW-1:0] ram_q_r;
    assign ram_q = ram_q_r;

    function automatic logic [DW-1:0] preload(input int a);
        return DW'(a % 7 + 1);
    endfunction

    initial begin
        for (int i = 0; i < FB; i++) mem[i] = preload(i);
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[4:0]] <= ram_wdata;
        ram_addr_r <= ram_addr;
        ram_q_r    <= mem[ram_addr_r[4:0]];
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [WEW-1:0] wr_exp_q[$];
    logic [REW-1:0] rd_exp_q[$];
    logic [DW-1:0]  shadow [FB];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_wr(input int c, input int a, input logic [DW-1:0] d, input logic fd);
        wr_exp_q.push_back({32'(c), fd, d, AW'(a)});
        shadow[a] = d;
    endtask

    task automatic exp_rd(input int c, input logic [DW-1:0] d);
        rd_exp_q.push_back({32'(c), d});
    endtask

    logic [WEW-1:0] wr_e;
    logic [WEW-1:0] wr_g;
    logic [REW-1:0] rd_e;
    logic [REW-1:0] rd_g;

    // Monitor: compares every RAM write and every read return against the queues.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            checks++;
            wr_g = {32'(cyc), frame_done, ram_wdata, ram_addr};
            if (wr_exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected actual addr=%0d data=%0d cycle=%0d required none",
                         ram_addr, ram_wdata, cyc);
            end else begin
                wr_e = wr_exp_q.pop_front();
                if (wr_g !== wr_e) begin
                    failures++;
                    $display("FAIL wr_txn actual cyc=%0d fd=%0d data=%0d addr=%0d required cyc=%0d fd=%0d data=%0d addr=%0d",
                             wr_g[WEW-1 -: 32], wr_g[DW+AW], wr_g[DW+AW-1 -: DW], wr_g[AW-1:0],
                             wr_e[WEW-1 -: 32], wr_e[DW+AW], wr_e[DW+AW-1 -: DW], wr_e[AW-1:0]);
                end
            end
        end else if (frame_done !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL fd_stray actual=%b required=0 cycle=%0d", frame_done, cyc);
        end
        if (rd_valid === 1'b1) begin
            checks++;
            rd_g = {32'(cyc), rd_data};
            if (rd_exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected actual data=%0d cycle=%0d required none", rd_data, cyc);
            end else begin
                rd_e = rd_exp_q.pop_front();
                if (rd_g !== rd_e) begin
                    failures++;
                    $display("FAIL rd_txn actual cyc=%0d data=%0d required cyc=%0d data=%0d",
                             rd_g[REW-1 -: 32], rd_g[DW-1:0], rd_e[REW-1 -: 32], rd_e[DW-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_clear_pass();
        for (int i = 0; i < FB; i++) exp_wr(cyc + i, i, '0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int c;
        for (int i = 0; i < FB; i++) shadow[i] = preload(i);

        // Reset state
        repeat (3) tick();
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_wdata", 32'(ram_wdata), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
`ifdef FB_ARB_CLEAR_EN
        chk("rst_busy", 32'(busy), 1);
`else
        chk("rst_busy", 32'(busy), 0);
`endif
        rst = 1'b0;
        k = cyc;
`ifdef FB_ARB_CLEAR_EN
        // Zero-fill pass; a read during it returns zero.
        expect_clear_pass();
        tick();
        tick();
        rd_req = 1'b1; rd_addr = AW'(5);
        exp_rd(cyc + 2, '0);
        tick();
        rd_req = 1'b0;
        chk("clear_busy_high", 32'(busy), 1);
        repeat (k + FB - cyc) tick();
        chk("clear_busy_fall", 32'(busy), 0);
`endif
        tick();
        tick();
        chk("run_state", 32'(state_dbg), 32'(S_RUN));

        // Four pixels with an idle read port: written the next cycle onwards.
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = DW'(i + 1);
            exp_wr(cyc + 1, i, DW'(i + 1), 1'b0);
            tick();
        end
        wr_valid = 1'b0;
        repeat (3) tick();

        // Continuous reads while 10 pixels arrive: 8 buffered, 2 dropped.
        wr_sof = 1'b1;
        tick();
        wr_sof = 1'b0;
        c = cyc;
        for (int i = 0; i < 12; i++) begin
            rd_req = 1'b1; rd_addr = AW'(16 + i);
            exp_rd(cyc + 2, shadow[16 + i]);
            wr_valid = (i < 10);
            wr_data  = DW'(i + 1);
            tick();
        end
        rd_req = 1'b0; wr_valid = 1'b0;
        chk("blocked_fifo_level", 32'(fifo_level_dbg), 8);
        chk("blocked_overflow", 32'(overflow), 1);
        chk("blocked_drop_cnt", 32'(drop_cnt), 2);
        for (int j = 0; j < 8; j++) exp_wr(c + 12 + j, j, DW'(j + 1), 1'b0);
        repeat (10) tick();

        // Start of frame clears overflow, then a stream crossing the frame wrap.
        wr_sof = 1'b1;
        tick();
        wr_sof = 1'b0;
        chk("sof_overflow_clr", 32'(overflow), 0);
        chk("sof_drop_cnt_kept", 32'(drop_cnt), 2);
        for (int i = 0; i < FB + 1; i++) begin
            wr_valid = 1'b1; wr_data = DW'(i * 5 + 3);
            exp_wr(cyc + 1, i % FB, DW'(i * 5 + 3), (i % FB) == FB - 1);
            tick();
        end
        wr_valid = 1'b0;
        repeat (3) tick();

        // Fill FIFO under reads (one drop), then sof with a pixel in the same cycle.
        for (int i = 0; i < 9; i++) begin
            rd_req = 1'b1; rd_addr = AW'(i);
            exp_rd(cyc + 2, shadow[i]);
            wr_valid = 1'b1; wr_data = DW'(7 - i);
            tick();
        end
        chk("pre_sof_overflow", 32'(overflow), 1);
        chk("pre_sof_drop_cnt", 32'(drop_cnt), 3);
        rd_req = 1'b0;
        wr_sof = 1'b1; wr_valid = 1'b1; wr_data = DW'(6);
        exp_wr(cyc + 1, 0, DW'(6), 1'b0);
        tick();
        wr_sof = 1'b0; wr_valid = 1'b0;
        chk("sof_fifo_level", 32'(fifo_level_dbg), 1);
        chk("sof_pix_overflow", 32'(overflow), 0);
        chk("sof_pix_drop_cnt", 32'(drop_cnt), 3);
        repeat (5) tick();

        // Back-to-back reads of written data.
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1; rd_addr = AW'(i);
            exp_rd(cyc + 2, shadow[i]);
            tick();
        end
        rd_req = 1'b0;
        repeat (4) tick();

        // Reset mid-operation: read pipeline and buffered pixel are discarded.
        rd_req = 1'b1; rd_addr = AW'(3); wr_valid = 1'b1; wr_data = DW'(1);
        tick();
        rd_req = 1'b1; rd_addr = AW'(4); wr_valid = 1'b1; wr_data = DW'(2); rst = 1'b1;
        tick();
        rd_req = 1'b0; wr_valid = 1'b0; rst = 1'b0;
`ifdef FB_ARB_CLEAR_EN
        expect_clear_pass();
        repeat (FB + 8) tick();
`else
        repeat (8) tick();
`endif
        chk("post_rst_drop_cnt", 32'(drop_cnt), 0);
        chk("post_rst_overflow", 32'(overflow), 0);
        chk("wr_queue_drained", 32'(wr_exp_q.size()), 0);
        chk("rd_queue_drained", 32'(rd_exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
